// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage controller: FSM encoding and datapath widths.
package mem_stage_ctrl_pkg;

  localparam int DATA_W        = 32;
  localparam int REG_W         = 4;
  localparam int BASE_ADDR_DEF = 1024;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/mem_stage_ctrl_wb_reg.sv
// MEM/WB pipeline register: full load, bubble insertion and a separately enabled read-value field.
module mem_wb_reg
  import mem_stage_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_rdata,
  input  logic              bubble,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] read_value_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] read_value,
  output logic [REG_W-1:0]  dest
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      alu_result <= '0;
      read_value <= '0;
      dest       <= '0;
    end else begin
      // A bubble only kills the control bits; data fields hold their last value.
      if (bubble) begin
        wb_en    <= 1'b0;
        mem_r_en <= 1'b0;
      end else if (load) begin
        wb_en      <= wb_en_in;
        mem_r_en   <= mem_r_en_in;
        alu_result <= alu_result_in;
        dest       <= dest_in;
      end
      if (load_rdata) read_value <= read_value_in;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: drives a req/ack data-memory access, stalls upstream while it is in flight,
// and feeds the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int BASE_ADDR = BASE_ADDR_DEF,
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN_IN,
  input  logic              MEM_R_EN_IN,
  input  logic              MEM_W_EN_IN,
  input  logic [DATA_W-1:0] ALU_result_IN,
  input  logic [DATA_W-1:0] Val_Rm_IN,
  input  logic [REG_W-1:0]  Dest_IN,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              ready,
  output logic              mem_err,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] Mem_read_value,
  output logic [REG_W-1:0]  Dest
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rbuf;
  logic              mem_op;

  assign mem_op = MEM_R_EN_IN | MEM_W_EN_IN;
  assign ready  = ((state == ST_IDLE) && !mem_op) || (state == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rbuf      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_op) begin
            // Word address relative to BASE_ADDR; byte-offset bits are dropped, no alignment check.
            mem_addr  <= ADDR_W'((ALU_result_IN - 32'(BASE_ADDR)) >> 2);
            mem_wdata <= Val_Rm_IN;
            mem_we    <= MEM_W_EN_IN;
            mem_req   <= 1'b1;
            cnt       <= '0;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // An ack on the final counted cycle still completes the access normally.
          if (mem_ack) begin
            if (!mem_we) rbuf <= mem_rdata;
            mem_req <= 1'b0;
            state   <= ST_DONE;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            rbuf    <= '0;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_wb_reg u_mem_wb (
    .clk           (clk),
    .rst_n         (rst),
    .load          (ready),
    .load_rdata    (state == ST_DONE),
    .bubble        (!ready),
    .wb_en_in      (WB_EN_IN),
    .mem_r_en_in   (MEM_R_EN_IN),
    .alu_result_in (ALU_result_IN),
    .read_value_in (rbuf),
    .dest_in       (Dest_IN),
    .wb_en         (WB_EN),
    .mem_r_en      (MEM_R_EN),
    .alu_result    (ALU_result),
    .read_value    (Mem_read_value),
    .dest          (Dest)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized instructions against a
// transaction-level model of stall length, memory-port values and MEM/WB results.
module tb_mem_stage_ctrl;

  localparam int T_OUT = 4;
  localparam int BASE  = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WB_EN_IN = 1'b0, MEM_R_EN_IN = 1'b0, MEM_W_EN_IN = 1'b0;
  logic [31:0] ALU_result_IN = '0, Val_Rm_IN = '0, mem_rdata = '0;
  logic [3:0]  Dest_IN = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, ready, mem_err, WB_EN, MEM_R_EN;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, ALU_result, Mem_read_value;
  logic [3:0]  Dest;

  mem_stage_ctrl #(.BASE_ADDR(BASE), .ADDR_W(16), .TIMEOUT(T_OUT)) dut (
    .clk(clk), .rst(rst),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .ALU_result_IN(ALU_result_IN), .Val_Rm_IN(Val_Rm_IN), .Dest_IN(Dest_IN),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ready(ready), .mem_err(mem_err),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
    .Mem_read_value(Mem_read_value), .Dest(Dest)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        exp_err = 1'b0;
  logic [31:0] rbuf_m = '0;
  logic [31:0] mrv_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start at posedge+1. k = cycle of ACCESS in which ack is presented (0 = never).
  task automatic run_instr(input logic wb, input logic r, input logic w,
                           input logic [31:0] alu, input logic [31:0] val,
                           input logic [3:0] dest, input int k,
                           input logic [31:0] rdata, input logic stray);
    logic        op, acked;
    int          cyc, low, exp_low;
    logic        ready_seen;
    logic [31:0] off;
    op    = r | w;
    WB_EN_IN = wb; MEM_R_EN_IN = r; MEM_W_EN_IN = w;
    ALU_result_IN = alu; Val_Rm_IN = val; Dest_IN = dest; mem_rdata = rdata;
    acked   = op && (k >= 1) && (k <= T_OUT);
    exp_low = !op ? 0 : (acked ? k + 1 : T_OUT + 1);
    off     = alu - 32'(BASE);
    cyc = 0; low = 0; ready_seen = 1'b0;
    while (cyc < 40) begin
      mem_ack = ((k >= 1) && (cyc == k)) || (stray && (cyc == 0));
      @(negedge clk);
      if (ready) begin
        ready_seen = 1'b1;
        break;
      end
      low++;
      check("req_during_stall", 32'(mem_req), 32'(cyc >= 1));
      if (cyc == 1) begin
        check("mem_we", 32'(mem_we), 32'(w));
        check("mem_addr", 32'(mem_addr), 32'(off[17:2]));
        check("mem_wdata", mem_wdata, val);
      end
      if (cyc >= 1) check("bubble_wb_en", 32'(WB_EN), 32'(0));
      @(posedge clk); #1;
      cyc++;
    end
    check("ready_returned", 32'(ready_seen), 32'(1));
    check("stall_len", 32'(low), 32'(exp_low));
    check("req_low_when_ready", 32'(mem_req), 32'(0));
    if (op) begin
      if (acked) begin
        if (!w) rbuf_m = rdata;
      end else begin
        exp_err = 1'b1;
        rbuf_m  = '0;
      end
      mrv_m = rbuf_m;
    end
    check("mem_err", 32'(mem_err), 32'(exp_err));
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("wb_en_out", 32'(WB_EN), 32'(wb));
    check("mem_r_en_out", 32'(MEM_R_EN), 32'(r));
    check("alu_out", ALU_result, alu);
    check("dest_out", 32'(Dest), 32'(dest));
    check("read_value", Mem_read_value, mrv_m);
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    // reset state
    #2;
    check("rst_req", 32'(mem_req), 32'(0));
    check("rst_wb_en", 32'(WB_EN), 32'(0));
    check("rst_alu", ALU_result, 32'(0));
    check("rst_err", 32'(mem_err), 32'(0));
    check("rst_ready", 32'(ready), 32'(1));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // ALU-only
    run_instr(1'b1, 1'b0, 1'b0, 32'h42, 32'h0, 4'd3, 0, 32'h0, 1'b0);
    // Load, ack after 3
    run_instr(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd5, 3, 32'hDEADBEEF, 1'b0);
    // Store, ack after 1
    run_instr(1'b0, 1'b0, 1'b1, 32'd1024, 32'h12345678, 4'd0, 1, 32'h0, 1'b0);
    // Ack on the last allowed cycle still succeeds
    run_instr(1'b1, 1'b1, 1'b0, 32'd1100, 32'h0, 4'd7, T_OUT, 32'hA5A5_0001, 1'b0);
    // Timeout: no ack
    run_instr(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd2, 0, 32'h1111_2222, 1'b0);
    // Late ack arriving in DONE is ignored; error stays sticky
    run_instr(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd4, T_OUT + 1, 32'h3333_4444, 1'b0);
    run_instr(1'b1, 1'b1, 1'b0, 32'd1044, 32'h0, 4'd6, 2, 32'h5555_6666, 1'b0);
    // Both enables: write wins, MEM_R_EN forwarded, read buffer untouched
    run_instr(1'b1, 1'b1, 1'b1, 32'd1048, 32'hCAFE_F00D, 4'd9, 2, 32'h7777_8888, 1'b0);

    // Reset mid-access
    WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b1; MEM_W_EN_IN = 1'b0; ALU_result_IN = 32'd1060;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("pre_rst_req", 32'(mem_req), 32'(1));
    rst = 1'b0;
    #1;
    check("midrst_req", 32'(mem_req), 32'(0));
    check("midrst_err", 32'(mem_err), 32'(0));
    check("midrst_addr", 32'(mem_addr), 32'(0));
    check("midrst_rval", Mem_read_value, 32'(0));
    check("midrst_alu", ALU_result, 32'(0));
    check("midrst_dest", 32'(Dest), 32'(0));
    WB_EN_IN = 1'b0; MEM_R_EN_IN = 1'b0; ALU_result_IN = '0;
    exp_err = 1'b0; rbuf_m = '0; mrv_m = '0;
    @(negedge clk); rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(ready), 32'(1));
    @(posedge clk); #1;
    check("post_rst_req", 32'(mem_req), 32'(0));

    // Stray ack in IDLE, then back-to-back loads (one with a stray ack in its IDLE cycle)
    run_instr(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 4'd1, 0, 32'hBAD0_BAD0, 1'b1);
    run_instr(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd8, 2, 32'h0BAD_CAFE, 1'b1);
    run_instr(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd10, 1, 32'h1234_ABCD, 1'b0);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'(BASE) + 32'($urandom_range(0, 32'h3FFFF));
      run_instr(1'($urandom_range(0, 1)), (sel == 1) || (sel == 3), (sel == 2) || (sel == 3),
                a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 6),
                $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
